// File: rtl/shift_rot_pipe.sv
// Pipelined barrel shifter/rotator: each registered stage applies one amount bit.
// Valid/ready on both sides with a bubble-collapsing advance chain and a sideband tag.
module shift_rot_pipe #(
    parameter int WIDTH = 16,
    parameter int TAG_W = 4,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [2:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [2:0] OpRol = 3'b000;
    localparam logic [2:0] OpSll = 3'b001;
    localparam logic [2:0] OpRor = 3'b010;
    localparam logic [2:0] OpSrl = 3'b011;
    localparam logic [2:0] OpSra = 3'b100;

    if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : gen_width_chk
        $error("shift_rot_pipe: WIDTH must be a power of two >= 4");
    end

    logic [SHW-1:0]   vld_q;
    logic [SHW-1:0]   adv;
    logic [WIDTH-1:0] data_q [SHW];
    logic [WIDTH-1:0] data_d [SHW];
    logic [SHW-1:0]   amt_q  [SHW];
    logic [2:0]       op_q   [SHW];
    logic [TAG_W-1:0] tag_q  [SHW];
    logic             unused_amt_op;

    function automatic logic [WIDTH-1:0] shift_by(input logic [WIDTH-1:0] d,
                                                  input logic [2:0] op,
                                                  input int unsigned sh);
        logic [WIDTH-1:0] r;
        case (op)
            OpRol:   r = (d << sh) | (d >> (WIDTH - sh));
            OpSll:   r = d << sh;
            OpRor:   r = (d >> sh) | (d << (WIDTH - sh));
            OpSrl:   r = d >> sh;
            OpSra:   r = $signed(d) >>> sh;
            default: r = d;
        endcase
        return r;
    endfunction

    // A stage may move when it is empty or everything downstream of it can move.
    always_comb begin
        for (int k = 0; k < SHW; k++) begin
            logic a;
            a = out_ready;
            for (int j = k; j < SHW; j++) begin
                a = a | ~vld_q[j];
            end
            adv[k] = a;
        end
    end

    always_comb begin
        data_d[0] = in_amt[0] ? shift_by(in_data, in_op, 1) : in_data;
        for (int k = 1; k < SHW; k++) begin
            data_d[k] = amt_q[k-1][k] ? shift_by(data_q[k-1], op_q[k-1], 1 << k)
                                      : data_q[k-1];
        end
    end

    // The last stage's amount/op and each stage's already-applied amount bits are not consumed.
    always_comb begin
        unused_amt_op = 1'b0;
        for (int k = 0; k < SHW; k++) begin
            unused_amt_op = unused_amt_op ^ (^amt_q[k]) ^ (^op_q[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int k = 0; k < SHW; k++) begin
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                op_q[k]   <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            if (flush) begin
                vld_q[0] <= 1'b0;
            end else if (adv[0]) begin
                vld_q[0] <= in_valid;
            end
            if (adv[0]) begin
                data_q[0] <= data_d[0];
                amt_q[0]  <= in_amt;
                op_q[0]   <= in_op;
                tag_q[0]  <= in_tag;
            end
            for (int k = 1; k < SHW; k++) begin
                if (flush) begin
                    vld_q[k] <= 1'b0;
                end else if (adv[k]) begin
                    vld_q[k] <= vld_q[k-1];
                end
                if (adv[k]) begin
                    data_q[k] <= data_d[k];
                    amt_q[k]  <= amt_q[k-1];
                    op_q[k]   <= op_q[k-1];
                    tag_q[k]  <= tag_q[k-1];
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[SHW-1];
    assign out_data  = data_q[SHW-1];
    assign out_tag   = tag_q[SHW-1];

endmodule

// File: tb/tb_shift_rot_pipe.sv
// Self-checking bench for shift_rot_pipe (WIDTH=16, TAG_W=4) with a bit-level reference model.
module tb_shift_rot_pipe;
    localparam int W  = 16;
    localparam int TW = 4;

    localparam logic [15:0] TVecD [7] = '{16'h1234, 16'h8001, 16'h0001, 16'h8000,
                                          16'h8000, 16'h7FF0, 16'hBEEF};
    localparam logic [3:0]  TVecA [7] = '{4'd4, 4'd1, 4'd15, 4'd15, 4'd15, 4'd4, 4'd3};
    localparam logic [2:0]  TVecO [7] = '{3'd2, 3'd0, 3'd1, 3'd3, 3'd4, 3'd4, 3'd6};
    localparam logic [15:0] TVecR [7] = '{16'h4123, 16'h0003, 16'h8000, 16'h0001,
                                          16'hFFFF, 16'h07FF, 16'hBEEF};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic [3:0]    in_amt;
    logic [2:0]    in_op;
    logic [TW-1:0] in_tag;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;

    int total = 0;
    int bad   = 0;
    logic [TW+W-1:0] exp_q[$];

    shift_rot_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_amt(in_amt),
        .in_op(in_op), .in_tag(in_tag), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Each result bit named by where it comes from in the operand.
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input logic [2:0] op,
                                               input int s);
        logic [W-1:0] r;
        r = d;
        for (int i = 0; i < W; i++) begin
            case (op)
                3'd0:    r[(i + s) % W] = d[i];
                3'd1:    r[i] = (i >= s) ? d[(i - s + W) % W] : 1'b0;
                3'd2:    r[i] = d[(i + s) % W];
                3'd3:    r[i] = (i + s < W) ? d[(i + s) % W] : 1'b0;
                3'd4:    r[i] = (i + s < W) ? d[(i + s) % W] : d[W-1];
                default: r[i] = d[i];
            endcase
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [W-1:0] d, input logic [3:0] a,
                         input logic [2:0] op, input logic [TW-1:0] t);
        in_valid = v;
        in_data  = d;
        in_amt   = a;
        in_op    = op;
        in_tag   = t;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req();
        exp_q.push_back({in_tag, ref_shift(in_data, in_op, int'(in_amt))});
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 16'hFFFF, 4'd3, 3'd1, 4'hF);
        #12;
        total++; if (out_valid !== 1'b0) begin bad++;
            $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 16'h0000) begin bad++;
            $display("FAIL reset_out_data: got %h want 0000", out_data); end
        total++; if (out_tag !== 4'h0) begin bad++;
            $display("FAIL reset_out_tag: got %h want 0", out_tag); end
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        drive(1'b0, '0, '0, '0, '0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        tick();
    endtask

    task automatic test_ops();
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, TVecD[i], TVecA[i], TVecO[i], TW'(i));
            @(negedge clk);
            total++; if (in_ready !== 1'b1) begin bad++;
                $display("FAIL ops_in_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            drive(1'b0, '0, '0, '0, '0);
            lat = 1;
            while (lat <= 12) begin
                @(negedge clk);
                if (out_valid) break;
                lat++;
                tick();
            end
            total++; if (lat != 4) begin bad++;
                $display("FAIL ops_latency[%0d]: got %0d want 4", i, lat); end
            total++; if (out_data !== TVecR[i]) begin bad++;
                $display("FAIL ops_data[%0d]: got %h want %h", i, out_data, TVecR[i]); end
            total++; if (out_tag !== TW'(i)) begin bad++;
                $display("FAIL ops_tag[%0d]: got %h want %h", i, out_tag, TW'(i)); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int got = 0;
        exp_q.delete();
        out_ready = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (c < 8) drive(1'b1, W'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), TW'(c));
            else drive(1'b0, '0, '0, '0, '0);
            @(negedge clk);
            if (c < 8) begin
                total++; if (in_ready !== 1'b1) begin bad++;
                    $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, in_ready); end
                push_req();
            end
            if (out_valid) begin
                total++; if (c != 4 + got) begin bad++;
                    $display("FAIL b2b_timing: result %0d at cycle %0d want %0d", got, c, 4 + got);
                end
                total++;
                if (exp_q.size() == 0) begin bad++;
                    $display("FAIL b2b_spurious: got tag %h data %h want none", out_tag, out_data);
                end else begin
                    if ({out_tag, out_data} !== exp_q[0]) begin bad++;
                        $display("FAIL b2b_result: got %h want %h", {out_tag, out_data}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                got++;
            end
            tick();
        end
        total++; if (got != 8) begin bad++;
            $display("FAIL b2b_count: got %0d want 8", got); end
    endtask

    task automatic test_backpressure();
        int acc = 0, got = 0, unstable = 0;
        logic seen = 1'b0;
        logic [W-1:0] snap = '0;
        logic [W-1:0] d = W'($urandom);
        logic [3:0] a = 4'($urandom);
        logic [2:0] op = 3'($urandom_range(0, 7));
        exp_q.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, d, a, op, TW'(acc));
            @(negedge clk);
            if (in_ready) begin
                push_req();
                acc++;
                d = W'($urandom); a = 4'($urandom); op = 3'($urandom_range(0, 7));
            end
            if (out_valid) begin
                if (!seen) begin seen = 1'b1; snap = out_data; end
                else if (out_data !== snap) unstable++;
            end
            tick();
        end
        drive(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        total++; if (acc != 4) begin bad++;
            $display("FAIL bp_accepted: got %0d want 4", acc); end
        total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++;
            $display("FAIL bp_full: in_ready=%b out_valid=%b want 0/1", in_ready, out_valid); end
        total++; if (unstable != 0 || out_data !== snap) begin bad++;
            $display("FAIL bp_stable: changes=%0d data=%h want 0 changes data %h",
                     unstable, out_data, snap);
        end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got++;
                total++;
                if (exp_q.size() == 0) begin bad++;
                    $display("FAIL bp_dup: got tag %h want none", out_tag);
                end else begin
                    if ({out_tag, out_data} !== exp_q[0]) begin bad++;
                        $display("FAIL bp_drain: got %h want %h", {out_tag, out_data}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            tick();
        end
        total++; if (got != 4) begin bad++;
            $display("FAIL bp_drain_count: got %0d want 4", got); end
    endtask

    task automatic test_full_simul();
        int acc = 0, got = 0;
        exp_q.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 10 && acc < 4; c++) begin
            drive(1'b1, W'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), TW'(8 + acc));
            @(negedge clk);
            if (in_ready) begin push_req(); acc++; end
            tick();
        end
        drive(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++;
            $display("FAIL full_state: out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        tick();
        drive(1'b1, W'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), 4'hC);
        out_ready = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL full_simul_in_ready: got %b want 1", in_ready); end
        total++; if (out_valid !== 1'b1 || {out_tag, out_data} !== exp_q[0]) begin bad++;
            $display("FAIL full_simul_out: valid=%b got %h want %h",
                     out_valid, {out_tag, out_data}, exp_q[0]);
        end
        void'(exp_q.pop_front());
        push_req();
        tick();
        out_ready = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin bad++;
            $display("FAIL full_occupancy: out_valid=%b in_ready=%b want 1/0", out_valid, in_ready);
        end
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) begin
                got++;
                total++;
                if (exp_q.size() == 0) begin bad++;
                    $display("FAIL full_dup: got tag %h want none", out_tag);
                end else begin
                    if ({out_tag, out_data} !== exp_q[0]) begin bad++;
                        $display("FAIL full_drain: got %h want %h", {out_tag, out_data}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            tick();
        end
        total++; if (got != 4) begin bad++;
            $display("FAIL full_drain_count: got %0d want 4", got); end
    endtask

    task automatic test_flush();
        int bogus = 0, lat;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, W'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), TW'(1 + c));
            tick();
        end
        drive(1'b1, W'($urandom), 4'($urandom), 3'($urandom_range(0, 7)), 4'd4);
        flush = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++;
            $display("FAIL flush_next_cycle: out_valid=%b want 0", out_valid); end
        tick();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (out_valid) bogus++;
            tick();
        end
        total++; if (bogus != 0) begin bad++;
            $display("FAIL flush_leak: %0d flushed results seen want 0", bogus); end
        drive(1'b1, 16'h00F0, 4'd4, 3'd2, 4'd6);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        lat = 1;
        while (lat <= 12) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            tick();
        end
        total++; if (out_valid !== 1'b1 || out_tag !== 4'd6 || out_data !== 16'h000F) begin bad++;
            $display("FAIL flush_after: valid=%b tag=%h data=%h want 1/6/000f",
                     out_valid, out_tag, out_data);
        end
        tick();
    endtask

    task automatic test_async_reset();
        int lat;
        out_ready = 1'b0;
        for (int c = 0; c < 10 && !out_valid; c++) begin
            drive(1'b1, 16'hA5A5, 4'd0, 3'd5, 4'd9);
            tick();
        end
        drive(1'b0, '0, '0, '0, '0);
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++;
            $display("FAIL areset_pre: out_valid=%b want 1", out_valid); end
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++;
            $display("FAIL areset_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 16'h0000 || out_tag !== 4'h0) begin bad++;
            $display("FAIL areset_data: data=%h tag=%h want 0000/0", out_data, out_tag); end
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL areset_in_ready: got %b want 1", in_ready); end
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 16'h00FF, 4'd8, 3'd1, 4'd3);
        tick();
        drive(1'b0, '0, '0, '0, '0);
        lat = 1;
        while (lat <= 12) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            tick();
        end
        total++; if (lat != 4 || out_data !== 16'hFF00 || out_tag !== 4'd3) begin bad++;
            $display("FAIL areset_after: lat=%0d data=%h tag=%h want 4/ff00/3",
                     lat, out_data, out_tag);
        end
        tick();
    endtask

    task automatic test_random();
        logic hold = 1'b0, prev_stall = 1'b0;
        logic v = 1'b0;
        logic [W-1:0] d = '0;
        logic [3:0] a = '0;
        logic [2:0] op = '0;
        logic [TW-1:0] t = '0;
        logic [TW+W-1:0] prev = '0;
        exp_q.delete();
        for (int c = 0; c < 10000; c++) begin
            if (!hold) begin
                v = ($urandom_range(0, 3) != 0);
                d = W'($urandom); a = 4'($urandom); op = 3'($urandom_range(0, 7)); t = TW'($urandom);
            end
            drive(v, d, a, op, t);
            out_ready = ($urandom_range(0, 2) != 0);
            flush = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin bad++;
                    $display("FAIL rnd_spurious[%0d]: got %h want none", c, {out_tag, out_data});
                end else if ({out_tag, out_data} !== exp_q[0]) begin bad++;
                    $display("FAIL rnd_result[%0d]: got %h want %h", c, {out_tag, out_data},
                             exp_q[0]);
                end
                if (prev_stall) begin
                    total++; if ({out_tag, out_data} !== prev) begin bad++;
                        $display("FAIL rnd_stable[%0d]: got %h want %h", c, {out_tag, out_data},
                                 prev);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev = {out_tag, out_data};
            if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) push_req();
            hold = in_valid && !in_ready;
            tick();
        end
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, '0, '0, '0, '0);
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid) begin
                total++;
                if (exp_q.size() == 0) begin bad++;
                    $display("FAIL rnd_drain_spurious: got %h want none", {out_tag, out_data});
                end else begin
                    if ({out_tag, out_data} !== exp_q[0]) begin bad++;
                        $display("FAIL rnd_drain: got %h want %h", {out_tag, out_data}, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
            end
            tick();
        end
        total++; if (exp_q.size() != 0) begin bad++;
            $display("FAIL rnd_lost: %0d results missing want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_back_to_back();
        test_backpressure();
        test_full_simul();
        test_flush();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
